// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked parametrised ALU with registered flags and iterative multiply
module alu_pipe #(
    parameter int A_W   = 8,
    parameter int W     = 10,
    parameter int SHIFT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in1,
    input  logic [W-1:0]   in2,
    input  logic [2:0]     opcode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out1,
    output logic           flag_z,
    output logic           flag_c,
    output logic           flag_n,
    output logic           flag_v
);
    localparam int CW = $clog2(A_W + 1);
    localparam int PW = 2 * W;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [A_W-1:0]  mul_a;
    logic [PW-1:0]   mul_b;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic            accept, consume, is_mul, last_iter;
    logic [W-1:0]    a_ext;
    logic [W:0]      wide;
    logic [W-1:0]    res;
    logic            res_c, res_v;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign is_mul    = (opcode == 3'b111);
    assign a_ext     = W'(in1);
    assign last_iter = (cnt == CW'(1));
    // Multiplier bits are consumed LSB first; b is pre-shifted to match.
    assign acc_nxt   = mul_a[0] ? acc + mul_b : acc;

    always_comb begin
        wide  = '0;
        res   = in2;
        res_c = 1'b0;
        res_v = 1'b0;
        case (opcode)
            3'b001: begin
                wide  = {1'b0, in2} + {1'b0, a_ext};
                res   = wide[W-1:0];
                res_c = wide[W];
                res_v = (a_ext[W-1] == in2[W-1]) && (res[W-1] != in2[W-1]);
            end
            3'b010: begin
                wide  = {1'b0, in2} - {1'b0, a_ext};
                res   = wide[W-1:0];
                res_c = wide[W];
                res_v = (a_ext[W-1] != in2[W-1]) && (res[W-1] != in2[W-1]);
            end
            3'b011: begin
                wide  = {1'b0, in2} + (W+1)'(1);
                res   = wide[W-1:0];
                res_c = wide[W];
                res_v = !in2[W-1] && res[W-1];
            end
            3'b100: begin
                res   = in2 >> SHIFT;
                res_c = |in2[SHIFT-1:0];
            end
            3'b101: res = in2 & a_ext;
            3'b110: res = in2 ^ a_ext;
            default: res = in2;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && is_mul) state_nxt = MUL_BUSY;
            MUL_BUSY: if (last_iter)        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out1      <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (state == IDLE) begin
            if (accept && is_mul) begin
                mul_a     <= in1;
                mul_b     <= PW'(in2);
                acc       <= '0;
                cnt       <= CW'(A_W);
                // Any previous result was consumed on this edge (accept implies it).
                out_valid <= 1'b0;
            end else if (accept) begin
                out1      <= res;
                flag_z    <= (res == '0);
                flag_c    <= res_c;
                flag_n    <= res[W-1];
                flag_v    <= res_v;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end else begin
            acc   <= acc_nxt;
            mul_a <= mul_a >> 1;
            mul_b <= mul_b << 1;
            cnt   <= cnt - CW'(1);
            if (last_iter) begin
                out1      <= acc_nxt[W-1:0];
                flag_z    <= (acc_nxt[W-1:0] == '0);
                flag_c    <= |acc_nxt[PW-1:W];
                flag_n    <= acc_nxt[W-1];
                flag_v    <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;
    localparam int A_W   = 8;
    localparam int W     = 10;
    localparam int SHIFT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in1;
    logic [W-1:0]   in2;
    logic [2:0]     opcode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out1;
    logic           flag_z, flag_c, flag_n, flag_v;

    int tests  = 0;
    int errors = 0;

    alu_pipe #(.A_W(A_W), .W(W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out1(out1),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]     op;
        logic [A_W-1:0] x;
        logic [W-1:0]   y;
        logic [W-1:0]   r;
        logic [3:0]     f;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the opcode definitions; returns {result, z, c, n, v}.
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [A_W-1:0] x,
                                           input logic [W-1:0] y);
        longint m  = longint'(1) << W;
        longint h  = m / 2;
        longint a  = longint'(x);
        longint b  = longint'(y);
        longint sa = (a >= h) ? a - m : a;
        longint sb = (b >= h) ? b - m : b;
        longint full = b;
        longint s = 0;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [W-1:0] r;
        case (op)
            3'd1: begin full = b + a; c = full >= m; s = sb + sa; v = (s < -h) || (s >= h); end
            3'd2: begin full = b - a + m; c = a > b; s = sb - sa; v = (s < -h) || (s >= h); end
            3'd3: begin full = b + 1; c = full >= m; s = sb + 1; v = (s < -h) || (s >= h); end
            3'd4: begin
                full = b / (longint'(1) << SHIFT);
                c = (b % (longint'(1) << SHIFT)) != 0;
            end
            3'd5: full = b & a;
            3'd6: full = b ^ a;
            3'd7: begin full = b * a; c = full >= m; end
            default: full = b;
        endcase
        r = W'(full % m);
        return {r, r == '0, c, r[W-1], v};
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [A_W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int busy);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b1; opcode = op; in1 = x; in2 = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        busy = in_ready ? 0 : 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (!in_ready) busy++;
        end
    endtask

    logic [W+3:0] expq[$];
    logic [W+3:0] e;
    logic         pend, held;
    logic [W-1:0] held_v;
    int           lat, busy, nv;

    initial begin
        vecs[0]  = '{3'd1, 8'h01, 10'h3FF, 10'h000, 4'b1100};
        vecs[1]  = '{3'd1, 8'h01, 10'h1FF, 10'h200, 4'b0011};
        vecs[2]  = '{3'd2, 8'h07, 10'h005, 10'h3FE, 4'b0110};
        vecs[3]  = '{3'd4, 8'h00, 10'h007, 10'h001, 4'b0100};
        vecs[4]  = '{3'd7, 8'h0C, 10'h015, 10'h0FC, 4'b0000};
        vecs[5]  = '{3'd7, 8'hFF, 10'h3FF, 10'h301, 4'b0110};
        vecs[6]  = '{3'd0, 8'h00, 10'h2AA, 10'h2AA, 4'b0010};
        vecs[7]  = '{3'd3, 8'h00, 10'h3FF, 10'h000, 4'b1100};
        vecs[8]  = '{3'd3, 8'h00, 10'h1FF, 10'h200, 4'b0011};
        vecs[9]  = '{3'd5, 8'hF0, 10'h3CC, 10'h0C0, 4'b0000};
        vecs[10] = '{3'd6, 8'hFF, 10'h3FF, 10'h300, 4'b0010};
        vecs[11] = '{3'd2, 8'hFF, 10'h000, 10'h301, 4'b0110};
        vecs[12] = '{3'd4, 8'h00, 10'h3FC, 10'h0FF, 4'b0000};
        vecs[13] = '{3'd7, 8'h00, 10'h3FF, 10'h000, 4'b1000};

        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; opcode = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out1", out1, 0);
        chk("reset_flags", {flag_z, flag_c, flag_n, flag_v}, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);

        // Asynchronous reset mid-cycle clears a held result immediately.
        do_op(3'd1, 8'h01, 10'h004, lat, busy);
        chk("pre_async_out1", out1, 10'h005);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out1", out1, 0);
        chk("async_flags", {flag_z, flag_c, flag_n, flag_v}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("async_in_ready", in_ready, 1);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].x, vecs[i].y, lat, busy);
            chk($sformatf("vec%0d_out1", i), out1, vecs[i].r);
            chk($sformatf("vec%0d_flags", i), {flag_z, flag_c, flag_n, flag_v}, vecs[i].f);
            chk($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 3'd7) ? A_W + 1 : 1);
            chk($sformatf("vec%0d_stall", i), busy, (vecs[i].op == 3'd7) ? A_W : 0);
        end

        // Backpressure: four INCs, downstream stalls after the first.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd3; in1 = '0; in2 = 10'd10;
        @(posedge clk); #1;
        out_ready = 1'b0; in2 = 10'd20;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_out1", out1, 11);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("bp_seq_out1", out1, 10 * k + 1);
            chk("bp_seq_valid", out_valid, 1);
            in2 = W'(10 * (k + 1));
            if (k == 4) in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Reset in the middle of a multiply.
        in_valid = 1'b1; opcode = 3'd7; in1 = 8'hAB; in2 = 10'h155;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mulrst_busy", in_ready, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mulrst_valid", out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("mulrst_no_result", nv, 0);
        do_op(3'd1, 8'h03, 10'h005, lat, busy);
        chk("mulrst_add_out1", out1, 10'h008);
        chk("mulrst_add_latency", lat, 1);

        // Randomised traffic against the reference model.
        @(posedge clk); #1;
        pend = 1'b0; held = 1'b0; held_v = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (held) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_data", out1, held_v);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                in_valid = ($urandom_range(0, 2) != 0);
                opcode = 3'($urandom);
                in1 = A_W'($urandom);
                in2 = W'($urandom);
            end
            #1;
            held = out_valid && !out_ready;
            held_v = out1;
            if (out_valid && out_ready) begin
                chk("rnd_expected_pending", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("rnd_out1", out1, e[W+3:4]);
                    chk("rnd_flags", {flag_z, flag_c, flag_n, flag_v}, e[3:0]);
                end
            end
            pend = in_valid && !in_ready;
            if (in_valid && in_ready) expq.push_back(model(opcode, in1, in2));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin
            if (out_valid) begin
                e = expq.pop_front();
                chk("drain_out1", out1, e[W+3:4]);
                chk("drain_flags", {flag_z, flag_c, flag_n, flag_v}, e[3:0]);
            end
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
